// File: rtl/traffic_light_monitor.sv
// Traffic light lamp monitor: decodes observed lamp drives into phases, tracks dwell
// times and the A->B->C->D loop, and latches the first protocol fault.
module traffic_light_monitor #(
   parameter int MIN_DWELL = 2,
   parameter int MAX_DWELL = 40
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       WERed,
   input  logic       SNRed,
   input  logic       WEgreen,
   input  logic       SNgreen,
   input  logic       WEyellow,
   input  logic       SNyellow,
   input  logic       clr_fault,
   output logic [2:0] phase,
   output logic [5:0] dwell,
   output logic [5:0] last_dwell,
   output logic       phase_change,
   output logic       cycle_done,
   output logic [7:0] cycle_count,
   output logic       fault,
   output logic [2:0] fault_code
);

   typedef enum logic [2:0] {
      PH_DARK    = 3'd0,
      PH_STARTUP = 3'd1,
      PH_A       = 3'd2,
      PH_B       = 3'd3,
      PH_C       = 3'd4,
      PH_D       = 3'd5,
      PH_ILLEGAL = 3'd7
   } phase_t;

   typedef enum logic {
      SYNC,
      TRACK
   } mon_state_t;

   typedef enum logic [2:0] {
      FC_NONE    = 3'd0,
      FC_ILLEGAL = 3'd1,
      FC_ORDER   = 3'd2,
      FC_SHORT   = 3'd3,
      FC_LONG    = 3'd4
   } fault_code_t;

   logic [5:0]  w_lamp;
   logic [5:0]  r_lamp_q;
   phase_t      r_phase;
   phase_t      w_phase_dec;
   mon_state_t  r_state;
   mon_state_t  w_next_state;
   logic [5:0]  r_dwell;
   logic [5:0]  r_last_dwell;
   logic [5:0]  w_dwell_inc;
   logic        r_phase_change;
   logic        r_cycle_done;
   logic [7:0]  r_cycle_count;
   logic        r_fault;
   fault_code_t r_fault_code;
   logic        w_change;
   logic        w_in_loop;
   logic        w_legal_next;
   logic        w_fault_ev;
   fault_code_t w_code;
   logic        w_cycle;

   assign w_lamp = {WERed, SNRed, WEgreen, SNgreen, WEyellow, SNyellow};

   always_comb begin
      case (r_lamp_q)
         6'b000000: w_phase_dec = PH_DARK;
         6'b100000: w_phase_dec = PH_STARTUP;
         6'b010000: w_phase_dec = PH_A;
         6'b001000: w_phase_dec = PH_B;
         6'b000100: w_phase_dec = PH_C;
         6'b000010: w_phase_dec = PH_D;
         default:   w_phase_dec = PH_ILLEGAL;
      endcase
   end

   assign w_dwell_inc = (r_dwell == 6'd63) ? r_dwell : r_dwell + 6'd1;
   assign w_change    = (w_phase_dec != r_phase);
   assign w_in_loop   = (r_phase == PH_A) || (r_phase == PH_B) ||
                        (r_phase == PH_C) || (r_phase == PH_D);
   assign w_legal_next = ((r_phase == PH_A) && (w_phase_dec == PH_B)) ||
                         ((r_phase == PH_B) && (w_phase_dec == PH_C)) ||
                         ((r_phase == PH_C) && (w_phase_dec == PH_D)) ||
                         ((r_phase == PH_D) && (w_phase_dec == PH_A));

   // Checks run against the outgoing phase/dwell; branch order gives priority 1 > 2 > 3.
   always_comb begin
      w_fault_ev   = 1'b0;
      w_code       = FC_NONE;
      w_next_state = r_state;
      w_cycle      = 1'b0;
      if (w_change) begin
         if (w_phase_dec == PH_ILLEGAL) begin
            w_fault_ev   = 1'b1;
            w_code       = FC_ILLEGAL;
            w_next_state = SYNC;
         end else if (r_state == SYNC) begin
            if (w_phase_dec == PH_A)
               w_next_state = TRACK;
         end else if (w_phase_dec == PH_DARK) begin
            w_next_state = SYNC;
         end else if (!w_legal_next) begin
            w_fault_ev   = 1'b1;
            w_code       = FC_ORDER;
            w_next_state = SYNC;
         end else if (r_dwell < 6'(MIN_DWELL)) begin
            w_fault_ev   = 1'b1;
            w_code       = FC_SHORT;
            w_next_state = SYNC;
         end else if (r_phase == PH_D) begin
            w_cycle = 1'b1;
         end
      end else if ((r_state == TRACK) && w_in_loop && (r_dwell == 6'(MAX_DWELL - 1))) begin
         w_fault_ev   = 1'b1;
         w_code       = FC_LONG;
         w_next_state = SYNC;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lamp_q       <= '0;
         r_phase        <= PH_DARK;
         r_state        <= SYNC;
         r_dwell        <= '0;
         r_last_dwell   <= '0;
         r_phase_change <= 1'b0;
         r_cycle_done   <= 1'b0;
         r_cycle_count  <= '0;
         r_fault        <= 1'b0;
         r_fault_code   <= FC_NONE;
      end else begin
         r_lamp_q     <= w_lamp;
         r_state      <= w_next_state;
         r_cycle_done <= w_cycle;
         if (w_cycle)
            r_cycle_count <= r_cycle_count + 8'd1;
         if (w_change) begin
            r_phase        <= w_phase_dec;
            r_last_dwell   <= r_dwell;
            r_dwell        <= 6'd1;
            r_phase_change <= 1'b1;
         end else begin
            r_dwell        <= w_dwell_inc;
            r_phase_change <= 1'b0;
         end
         // A fault arriving with clr_fault is treated as the first fault after the clear.
         if (w_fault_ev) begin
            r_fault <= 1'b1;
            if (!r_fault || clr_fault)
               r_fault_code <= w_code;
         end else if (clr_fault) begin
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
         end
      end
   end

   assign phase        = r_phase;
   assign dwell        = r_dwell;
   assign last_dwell   = r_last_dwell;
   assign phase_change = r_phase_change;
   assign cycle_done   = r_cycle_done;
   assign cycle_count  = r_cycle_count;
   assign fault        = r_fault;
   assign fault_code   = r_fault_code;

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have parameter MIN_DWELL, default 2, meaning minimum legal cycles in a tracked phase.
REQ-002 SHALL have parameter MAX_DWELL, default 40, meaning maximum legal cycles in a tracked phase (must be 2..63).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports WERed, SNRed, WEgreen, SNgreen, WEyellow, SNyellow  input  1 each  observed lamp drives; vector L = {WERed,SNRed,WEgreen,SNgreen,WEyellow,SNyellow}.
REQ-006 SHALL have port clr_fault  input  1  clears the sticky fault.
REQ-007 SHALL have port phase  output  3  decoded phase: 0 DARK (L=000000), 1 STARTUP (100000), 2 A (010000), 3 B (001000), 4 C (000100), 5 D (000010), 7 ILLEGAL (any other L).
REQ-008 SHALL have port dwell  output  6  cycles the current phase has been held, saturating at 63.
REQ-009 SHALL have port last_dwell  output  6  dwell of the previous phase, captured at each change.
REQ-010 SHALL have port phase_change  output  1  one-cycle pulse when phase updates to a new value.
REQ-011 SHALL have port cycle_done  output  1  one-cycle pulse on a tracked D->A transition.
REQ-012 SHALL have port cycle_count  output  8  count of cycle_done pulses, wraps 255->0.
REQ-013 SHALL have port fault  output  1  sticky fault flag.
REQ-014 SHALL have port fault_code  output  3  first-fault cause: 0 none, 1 illegal vector, 2 out-of-order, 3 dwell too short, 4 dwell too long.

Function
REQ-015 SHALL register L into lamp_q each cycle; phase SHALL be decoded from lamp_q and registered, giving 2-cycle latency from an L change to phase/phase_change.
REQ-016 SHALL, on phase change: last_dwell <= dwell, dwell <= 1, phase_change <= 1; otherwise dwell <= min(dwell+1, 63).
REQ-017 SHALL implement monitor FSM with states SYNC and TRACK; reset state SYNC.
REQ-018 SHALL, in SYNC, move to TRACK when the new phase is A; no order or dwell checks in SYNC.
REQ-019 SHALL, in TRACK, treat legal changes as A->B, B->C, C->D, D->A, and any->DARK.
REQ-020 SHALL, in TRACK, flag code 2 on any other change to a non-ILLEGAL phase and go to SYNC.
REQ-021 SHALL, in TRACK, flag code 3 when leaving A..D with dwell < MIN_DWELL, and go to SYNC.
REQ-022 SHALL, in TRACK, flag code 4 in the cycle dwell reaches MAX_DWELL while still in A..D, and go to SYNC; DARK and STARTUP are exempt.
REQ-023 SHALL, in any state, flag code 1 when phase becomes ILLEGAL, and go to or stay in SYNC.
REQ-024 SHALL, in TRACK, go to SYNC without a fault on a change to DARK.
REQ-025 SHALL pulse cycle_done and increment cycle_count only on a D->A change in TRACK that causes no fault.
REQ-026 SHALL, on a fault, set fault <= 1 and set fault_code only if fault was 0; later faults SHALL NOT overwrite the first code.
REQ-027 SHALL apply priority code 1 > 2 > 3 when several causes occur in the same cycle.
REQ-028 SHALL, on clr_fault, clear fault and fault_code to 0; a new fault in the same cycle SHALL win and be recorded.

Reset
REQ-029 SHALL, when rst=1 at a clock edge, set lamp_q=0, phase=0, dwell=0, last_dwell=0, phase_change=0, cycle_done=0, cycle_count=0, fault=0, fault_code=0, FSM=SYNC; rst SHALL override clr_fault and all events, including mid-phase.

Verification
REQ-030 SHALL verify the legal loop: STARTUP 3 cycles, then A,B,C,D 10 cycles each, then A -> cycle_done once, cycle_count=1, last_dwell=10 at each change, fault=0.
REQ-031 SHALL verify an illegal vector: L=011000 for 1 cycle during B -> phase=7 and fault=1, code=1 after 2 cycles; a subsequent C is not order-checked until A resyncs.
REQ-032 SHALL verify order and first-fault retention: in TRACK, A->C -> code=2; then a B held 1 cycle leaves fault_code=2.
REQ-033 SHALL verify dwell limits: B held 1 cycle -> code=3; after clr_fault and a resync, C held 40 cycles -> code=4 in the cycle dwell=40.
REQ-034 SHALL verify a simultaneous event: clr_fault=1 in the same cycle as a new code-2 event -> fault=1, code=2.
REQ-035 SHALL verify reset mid-operation: rst pulse with dwell=25 and cycle_count=3 -> all outputs 0 next cycle; no fault until a new A is seen.
